// File: rtl/cache_req_arbiter_if.sv
// Bus bundles around the cache request arbiter: requester-side port set and
// the cin/cout-style command port towards the cache controller.

// Handshake: req is a level request held until its one-cycle ack; gnt marks
// ownership from ISSUE through WAIT; c_start is a single-cycle command strobe
// answered by c_done, with c_rdata valid in the same cycle as c_done.
interface cache_req_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      err;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, ack, rdata, err
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, ack, rdata, err
    );
endinterface

interface cache_cmd_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              c_start;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;

    modport master (
        output c_start, c_we, c_addr, c_wdata,
        input  c_done, c_rdata
    );

    modport slave (
        input  c_start, c_we, c_addr, c_wdata,
        output c_done, c_rdata
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache control unit among NUM_REQ requesters,
// with a bounded wait for completion and a one-cycle acknowledge per request.
module cache_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_b,
    cache_req_if.slave  rq,
    cache_cmd_if.master cc,
    output logic        busy,
    output logic [1:0]  state_dbg
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  arb_idx;
    logic [IDX_W-1:0]  cand;
    logic              arb_found;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [CNT_W-1:0]  cnt;
    logic              timeout_hit;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    // First requester with req high, scanning ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!arb_found && rq.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_we    = rq.req_we[i];
                sel_addr  = rq.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = rq.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (arb_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cc.c_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command fields are captured on the winning edge so later requester
    // changes cannot disturb an in-flight transaction.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        idx       <= arb_idx;
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (cc.c_done) begin
                        rdata_q <= cc.c_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: ptr <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rq.gnt     = '0;
        rq.ack     = '0;
        cc.c_start = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_ISSUE: begin
                cc.c_start  = 1'b1;
                rq.gnt[idx] = 1'b1;
            end
            S_WAIT:  rq.gnt[idx] = 1'b1;
            S_RESP:  rq.ack[idx] = 1'b1;
            default: ;
        endcase
    end

    assign cc.c_we    = lat_we;
    assign cc.c_addr  = lat_addr;
    assign cc.c_wdata = lat_wdata;
    assign rq.rdata   = rdata_q;
    assign rq.err     = err_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: stimulus pushes expected commands and
// responses; a monitor pops and compares whenever c_start or ack appears.
module tb_cache_req_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 15;
    localparam int CW = NR + 1 + AW + DW;
    localparam int RW = NR + 1 + DW + 8;
    localparam int KW = 2 + 8 + DW;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       busy;
    logic [1:0] state_dbg;

    cache_req_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) rif ();
    cache_cmd_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();

    cache_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .rq        (rif),
        .cc        (cif),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // requester state: req[i] stays high while issued[i] runs ahead of acked[i]
    int          issued[NR];
    int          acked[NR];
    logic        we_a[NR];
    logic [AW-1:0] addr_a[NR];
    logic [DW-1:0] wdata_a[NR];
    for (genvar g = 0; g < NR; g++) begin : g_req
        assign rif.req[g]                   = (issued[g] != acked[g]);
        assign rif.req_we[g]                = we_a[g];
        assign rif.req_addr[g*AW +: AW]     = addr_a[g];
        assign rif.req_wdata[g*DW +: DW]    = wdata_a[g];
    end

    logic          resp_done, stim_done;
    logic [DW-1:0] resp_rd, stim_rd;
    assign cif.c_done  = resp_done | stim_done;
    assign cif.c_rdata = resp_done ? resp_rd : stim_rd;

    logic [CW-1:0] exp_cmd_q[$];
    logic [RW-1:0] exp_q[$];
    logic [KW-1:0] cache_q[$];

    int n_vec = 0;
    int n_err = 0;
    int start_cyc = 0;
    int last_ack_cyc = 0;
    int total_acks = 0;
    int group_base = 0;
    int idle_run = 0;
    bit gap_chk = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cache model: replies per queued entry {issue_glitch, never, delay, rdata}.
    initial begin : responder
        logic [KW-1:0] k;
        resp_done = 1'b0;
        resp_rd   = '0;
        forever begin
            @(negedge clk);
            if (rst_b && cif.c_start && cache_q.size() > 0) begin
                k = cache_q.pop_front();
                if (k[KW-1]) begin
                    resp_done = 1'b1;
                    resp_rd   = 8'h11;
                end
                @(negedge clk);
                resp_done = 1'b0;
                resp_rd   = '0;
                if (!k[KW-2]) begin
                    repeat (int'(k[15:8])) @(negedge clk);
                    resp_done = 1'b1;
                    resp_rd   = k[7:0];
                    @(negedge clk);
                    resp_done = 1'b0;
                    resp_rd   = '0;
                end
            end
        end
    end

    initial begin : monitor
        logic [CW-1:0] ec;
        logic [RW-1:0] er;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                idle_run = 0;
            end else begin
                if (cif.c_start) begin
                    start_cyc = cyc;
                    if (exp_cmd_q.size() == 0) begin
                        check("cmd_unexpected", 32'(rif.gnt), 32'h0);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        check("cmd_gnt_we_addr_wdata",
                              32'({rif.gnt, cif.c_we, cif.c_addr, cif.c_wdata}), 32'(ec));
                    end
                end
                if (|rif.ack) begin
                    last_ack_cyc = cyc;
                    total_acks++;
                    for (int i = 0; i < NR; i++) if (rif.ack[i]) acked[i]++;
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", 32'(rif.ack), 32'h0);
                    end else begin
                        er = exp_q.pop_front();
                        check("rsp_ack_err_rdata", 32'({rif.ack, rif.err, rif.rdata}), 32'(er[RW-1:8]));
                        check("rsp_latency", 32'(cyc - start_cyc), 32'(er[7:0]));
                    end
                end
                if (!busy) begin
                    idle_run++;
                end else begin
                    if (gap_chk && idle_run > 0 && total_acks > group_base)
                        check("busy_gap", 32'(idle_run), 32'd1);
                    idle_run = 0;
                end
            end
        end
    end

    task automatic set_fields(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        we_a[i]    = we;
        addr_a[i]  = a;
        wdata_a[i] = d;
    endtask

    // delay<0 means the cache never answers: timeout response expected.
    task automatic expect_txn(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d,
                              bit glitch, int delay, logic [DW-1:0] rd, bit has_rsp);
        logic [NR-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        exp_cmd_q.push_back({oh, we, a, d});
        cache_q.push_back({glitch, (delay < 0), 8'((delay < 0) ? 0 : delay), rd});
        if (has_rsp) begin
            if (delay < 0) exp_q.push_back({oh, 1'b1, 8'h00, 8'(TO + 1)});
            else           exp_q.push_back({oh, 1'b0, rd, 8'(delay + 2)});
        end
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_cmd_q.size() != 0 || rif.req != '0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(n < 400), 32'd1);
        if (n >= 400) begin
            exp_q.delete();
            exp_cmd_q.delete();
            cache_q.delete();
            for (int i = 0; i < NR; i++) issued[i] = acked[i];
        end
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        for (int i = 0; i < NR; i++) issued[i] = acked[i];
        repeat (2) @(negedge clk);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_state",   32'(state_dbg), 32'd0);
        check("rst_gnt",     32'(rif.gnt), 32'd0);
        check("rst_ack",     32'(rif.ack), 32'd0);
        check("rst_rdata",   32'(rif.rdata), 32'd0);
        check("rst_err",     32'(rif.err), 32'd0);
        check("rst_c_start", 32'(cif.c_start), 32'd0);
        check("rst_c_we",    32'(cif.c_we), 32'd0);
        check("rst_c_addr",  32'(cif.c_addr), 32'd0);
        check("rst_c_wdata", 32'(cif.c_wdata), 32'd0);
        rst_b = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        int n;
        stim_done = 1'b0;
        stim_rd   = '0;
        for (int i = 0; i < NR; i++) begin
            issued[i] = 0;
            acked[i]  = 0;
            set_fields(i, 1'b0, '0, '0);
        end
        do_reset();

        // single read, c_done in the first WAIT cycle
        set_fields(0, 1'b0, 8'h3C, 8'h00);
        expect_txn(0, 1'b0, 8'h3C, 8'h00, 1'b0, 0, 8'hA5, 1'b1);
        @(negedge clk);
        t0 = cyc;
        issued[0]++;
        wait_drain("t1");
        check("t1_start_cycle", 32'(start_cyc - t0), 32'd1);
        check("t1_ack_cycle",   32'(last_ack_cyc - t0), 32'd3);
        check("t1_rdata_hold",  32'(rif.rdata), 32'hA5);
        check("t1_err",         32'(rif.err), 32'd0);
        check("t1_addr_hold",   32'(cif.c_addr), 32'h3C);
        check("t1_c_start_idle", 32'(cif.c_start), 32'd0);

        // all four requesting, requester 0 twice: order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) set_fields(i, (i % 2 == 1), 8'(8'h10 + i), 8'(8'h80 + i));
        expect_txn(0, 1'b0, 8'h10, 8'h80, 1'b0, 0, 8'hC0, 1'b1);
        expect_txn(1, 1'b1, 8'h11, 8'h81, 1'b0, 0, 8'hC1, 1'b1);
        expect_txn(2, 1'b0, 8'h12, 8'h82, 1'b0, 0, 8'hC2, 1'b1);
        expect_txn(3, 1'b1, 8'h13, 8'h83, 1'b0, 0, 8'hC3, 1'b1);
        expect_txn(0, 1'b0, 8'h10, 8'h80, 1'b0, 0, 8'hC4, 1'b1);
        group_base = total_acks;
        gap_chk    = 1'b1;
        @(negedge clk);
        issued[0] += 2;
        issued[1]++;
        issued[2]++;
        issued[3]++;
        wait_drain("t2");
        gap_chk = 1'b0;

        // stray c_done while idle, then done exactly at the timeout boundary
        @(negedge clk);
        stim_done = 1'b1;
        stim_rd   = 8'hEE;
        @(negedge clk);
        stim_done = 1'b0;
        stim_rd   = '0;
        @(negedge clk);
        check("idle_done_rdata", 32'(rif.rdata), 32'hC4);
        check("idle_done_state", 32'(state_dbg), 32'd0);
        set_fields(1, 1'b0, 8'h55, 8'h00);
        expect_txn(1, 1'b0, 8'h55, 8'h00, 1'b1, TO - 1, 8'h5A, 1'b1);
        @(negedge clk);
        issued[1]++;
        wait_drain("t4");
        check("t4_err",   32'(rif.err), 32'd0);
        check("t4_rdata", 32'(rif.rdata), 32'h5A);

        // write with no completion: timeout
        set_fields(2, 1'b1, 8'h7E, 8'h33);
        expect_txn(2, 1'b1, 8'h7E, 8'h33, 1'b0, -1, 8'h00, 1'b1);
        @(negedge clk);
        t0 = cyc;
        issued[2]++;
        wait_drain("t3");
        check("t3_ack_cycle", 32'(last_ack_cyc - t0), 32'(TO + 2));
        check("t3_err",       32'(rif.err), 32'd1);
        check("t3_rdata",     32'(rif.rdata), 32'h00);
        check("t3_state",     32'(state_dbg), 32'd0);
        check("t3_we_hold",   32'(cif.c_we), 32'd1);
        check("t3_wdata_hold", 32'(cif.c_wdata), 32'h33);

        // asynchronous reset in WAIT aborts without ack
        set_fields(0, 1'b0, 8'h21, 8'h00);
        expect_txn(0, 1'b0, 8'h21, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        @(negedge clk);
        issued[0]++;
        n = 0;
        while (state_dbg != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_wait", 32'(n < 20), 32'd1);
        repeat (3) @(negedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        check("t5_gnt",     32'(rif.gnt), 32'd0);
        check("t5_busy",    32'(busy), 32'd0);
        check("t5_c_start", 32'(cif.c_start), 32'd0);
        check("t5_ack",     32'(rif.ack), 32'd0);
        check("t5_err",     32'(rif.err), 32'd0);
        check("t5_c_addr",  32'(cif.c_addr), 32'd0);
        issued[0] = acked[0];
        @(negedge clk);
        check("t5_cmd_seen", 32'(exp_cmd_q.size()), 32'd0);
        rst_b = 1'b1;
        set_fields(1, 1'b0, 8'h42, 8'h00);
        set_fields(3, 1'b1, 8'h43, 8'h99);
        expect_txn(1, 1'b0, 8'h42, 8'h00, 1'b0, 0, 8'h77, 1'b1);
        expect_txn(3, 1'b1, 8'h43, 8'h99, 1'b0, 0, 8'h88, 1'b1);
        @(negedge clk);
        issued[1]++;
        issued[3]++;
        wait_drain("t5");

        // requester 0 re-requests right after its ack: order 0,1,0
        set_fields(0, 1'b0, 8'h01, 8'h00);
        set_fields(1, 1'b0, 8'h02, 8'h00);
        expect_txn(0, 1'b0, 8'h01, 8'h00, 1'b0, 0, 8'hD0, 1'b1);
        expect_txn(1, 1'b0, 8'h02, 8'h00, 1'b0, 0, 8'hD1, 1'b1);
        expect_txn(0, 1'b0, 8'h01, 8'h00, 1'b0, 0, 8'hD2, 1'b1);
        group_base = total_acks;
        gap_chk    = 1'b1;
        @(negedge clk);
        issued[0] += 2;
        issued[1]++;
        wait_drain("t6");
        gap_chk = 1'b0;
        check("t6_rdata", 32'(rif.rdata), 32'hD2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
